// File: rtl/clock_pkg.sv
// Shared definitions for the clock field counters: button FSM states,
// per-field ranges and the default button timing.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int SEC_MIN_VAL   = 0;
  localparam int SEC_MAX_VAL   = 59;
  localparam int MIN_MIN_VAL   = 0;
  localparam int MIN_MAX_VAL   = 59;
  localparam int HOUR_MIN_VAL  = 0;
  localparam int HOUR_MAX_VAL  = 23;
  localparam int DAY_MIN_VAL   = 1;
  localparam int DAY_MAX_VAL   = 31;
  localparam int MONTH_MIN_VAL = 1;
  localparam int MONTH_MAX_VAL = 12;

  localparam int HOLD_CYCLES_DEF   = 500;
  localparam int REPEAT_CYCLES_DEF = 100;

  // Integer arguments keep the check free of constant unsigned compares when lo is 0.
  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational binary to two-digit BCD split for values below 100.
module bin2bcd_2digit #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  logic [6:0] bin_ext;

  assign bin_ext = 7'(bin_i);

  // Threshold compare instead of a divider: only ten tens values exist.
  always_comb begin
    tens_o = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (bin_ext >= 7'(10 * k)) begin
        tens_o = 4'(k);
      end
    end
    ones_o = 4'(bin_ext - 7'(10 * tens_o));
  end

endmodule

// File: rtl/time_unit_counter.sv
// Modulo counter for one clock field: tick-driven count with carry, button
// setting with hold-to-repeat, parallel load and a BCD view of the value.
module time_unit_counter
  import clock_pkg::*;
#(
  parameter int MIN_VAL       = HOUR_MIN_VAL,
  parameter int MAX_VAL       = HOUR_MAX_VAL,
  parameter int WIDTH         = 5,
  parameter int RESET_VAL     = 0,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             set_up,
  input  logic             set_dn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             load_err,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX);

  localparam logic [WIDTH-1:0]   MIN_W       = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]   MAX_W       = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]   RESET_W     = WIDTH'(RESET_VAL);
  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LOAD = TIMER_W'(REPEAT_CYCLES - 1);

  btn_state_e         state_q;
  logic [TIMER_W-1:0] timer_q;
  logic               dir_up_q;

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             load_err_q, load_err_d;

  logic active;
  logic dir_up;
  logic dir_change;
  logic btn_step;

  // Both buttons pressed together is treated as no button at all.
  assign active     = set_up ^ set_dn;
  assign dir_up     = set_up;
  assign dir_change = (dir_up != dir_up_q);

  always_comb begin
    btn_step = 1'b0;
    case (state_q)
      ST_IDLE:             btn_step = active;
      ST_HOLD, ST_REPEAT:  btn_step = active && (dir_change || (timer_q == '0));
      default:             btn_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      dir_up_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (active) begin
            state_q  <= ST_HOLD;
            timer_q  <= HOLD_LOAD;
            dir_up_q <= dir_up;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!active) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end else if (dir_change) begin
            state_q  <= ST_HOLD;
            timer_q  <= HOLD_LOAD;
            dir_up_q <= dir_up;
          end else if (timer_q == '0) begin
            state_q <= ST_REPEAT;
            timer_q <= REPEAT_LOAD;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  // A step or tick that loses to a higher-priority event this cycle is simply lost.
  always_comb begin
    value_d    = value_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load_en) begin
      if (in_range(int'(load_val), MIN_VAL, MAX_VAL)) begin
        value_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (btn_step) begin
      if (dir_up) begin
        value_d = (value_q == MAX_W) ? MIN_W : value_q + WIDTH'(1);
      end else begin
        value_d = (value_q == MIN_W) ? MAX_W : value_q - WIDTH'(1);
      end
    end else if (tick) begin
      if (value_q == MAX_W) begin
        value_d = MIN_W;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= RESET_W;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign value    = value_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

  bin2bcd_2digit #(
    .WIDTH (WIDTH)
  ) u_bcd (
    .bin_i  (value_q),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: an hour-style field with short button
// timing, and a 1..12 field for the wrap-at-minimum cases.
module tb_time_unit_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tick_a, up_a, dn_a, ld_a;
  logic [4:0] lv_a, value_a;
  logic       carry_a, err_a;
  logic [3:0] tens_a, ones_a;

  logic       tick_b, up_b, dn_b, ld_b;
  logic [3:0] lv_b, value_b;
  logic       carry_b, err_b;
  logic [3:0] tens_b, ones_b;

  int n_checks = 0;
  int n_pass   = 0;

  time_unit_counter #(
    .MIN_VAL(0), .MAX_VAL(23), .WIDTH(5), .RESET_VAL(0),
    .HOLD_CYCLES(5), .REPEAT_CYCLES(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick_a), .set_up(up_a), .set_dn(dn_a),
    .load_en(ld_a), .load_val(lv_a), .value(value_a), .carry(carry_a),
    .load_err(err_a), .bcd_tens(tens_a), .bcd_ones(ones_a)
  );

  time_unit_counter #(
    .MIN_VAL(1), .MAX_VAL(12), .WIDTH(4), .RESET_VAL(1),
    .HOLD_CYCLES(500), .REPEAT_CYCLES(100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick_b), .set_up(up_b), .set_dn(dn_b),
    .load_en(ld_b), .load_val(lv_b), .value(value_b), .carry(carry_b),
    .load_err(err_b), .bcd_tens(tens_b), .bcd_ones(ones_b)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
      $display("check %-14s got %0d expected %0d ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_hold[12] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5};

  initial begin
    rst_n = 1'b0;
    {tick_a, up_a, dn_a, ld_a} = '0;
    lv_a = '0;
    {tick_b, up_b, dn_b, ld_b} = '0;
    lv_b = '0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_val_a", value_a, 0);
    check_val("rst_carry_a", carry_a, 0);
    check_val("rst_err_a", err_a, 0);
    check_val("rst_tens_a", tens_a, 0);
    check_val("rst_ones_a", ones_a, 0);
    check_val("rst_val_b", value_b, 1);
    check_val("rst_ones_b", ones_b, 1);
    @(negedge clk) rst_n = 1'b1;

    // 1..12 field: down-wrap at minimum, up-wrap at maximum, tick carry
    dn_b = 1'b1; cyc(); dn_b = 1'b0;
    check_val("dn_wrap_b", value_b, 12);
    check_val("dn_carry_b", carry_b, 0);
    check_val("dn_tens_b", tens_b, 1);
    check_val("dn_ones_b", ones_b, 2);
    cyc();
    up_b = 1'b1; cyc(); up_b = 1'b0;
    check_val("up_wrap_b", value_b, 1);
    check_val("up_carry_b", carry_b, 0);
    cyc();
    dn_b = 1'b1; cyc(); dn_b = 1'b0;
    check_val("dn_again_b", value_b, 12);
    cyc();
    tick_b = 1'b1; cyc(); tick_b = 1'b0;
    check_val("tick_wrap_b", value_b, 1);
    check_val("tick_carry_b", carry_b, 1);
    cyc();
    check_val("carry_drop_b", carry_b, 0);

    // 24 back-to-back ticks through the full 0..23 range
    tick_a = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      check_val("tick_val", value_a, (i + 1) % 24);
      check_val("tick_carry", carry_a, (i == 23) ? 1 : 0);
      if (i == 22) begin
        check_val("bcd_tens_23", tens_a, 2);
        check_val("bcd_ones_23", ones_a, 3);
      end
    end
    tick_a = 1'b0;
    cyc();
    check_val("carry_drop", carry_a, 0);

    // hold set_up 12 cycles: steps after edges 0,5,7,9,11
    up_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check_val("hold_val", value_a, exp_hold[k]);
      check_val("hold_carry", carry_a, 0);
    end
    up_a = 1'b0;
    repeat (3) begin
      cyc();
      check_val("release_val", value_a, 5);
    end
    up_a = 1'b1; cyc(); up_a = 1'b0;
    check_val("repress_step", value_a, 6);
    cyc();

    // parallel load: out of range then in range
    ld_a = 1'b1; lv_a = 5'd30; cyc(); ld_a = 1'b0;
    check_val("bad_load_val", value_a, 6);
    check_val("bad_load_err", err_a, 1);
    check_val("bad_load_cry", carry_a, 0);
    cyc();
    check_val("err_drop", err_a, 0);
    check_val("err_drop_val", value_a, 6);
    ld_a = 1'b1; lv_a = 5'd17; cyc(); ld_a = 1'b0;
    check_val("load17_val", value_a, 17);
    check_val("load17_tens", tens_a, 1);
    check_val("load17_ones", ones_a, 7);
    check_val("load17_carry", carry_a, 0);
    check_val("load17_err", err_a, 0);

    ld_a = 1'b1; lv_a = 5'd0; cyc(); ld_a = 1'b0;
    check_val("load0_val", value_a, 0);
    dn_a = 1'b1; cyc(); dn_a = 1'b0;
    check_val("dn_wrap_a", value_a, 23);
    check_val("dn_carry_a", carry_a, 0);
    cyc();

    // priority: load beats button beats tick
    ld_a = 1'b1; lv_a = 5'd5; up_a = 1'b1; tick_a = 1'b1; cyc(); ld_a = 1'b0;
    check_val("prio_load", value_a, 5);
    check_val("prio_ld_cry", carry_a, 0);
    cyc();
    check_val("prio_next", value_a, 6);
    check_val("prio_nx_cry", carry_a, 0);
    up_a = 1'b0; tick_a = 1'b0;
    cyc();
    ld_a = 1'b1; lv_a = 5'd23; cyc(); ld_a = 1'b0;
    check_val("load23", value_a, 23);
    up_a = 1'b1; tick_a = 1'b1; cyc(); up_a = 1'b0; tick_a = 1'b0;
    check_val("set_vs_tick", value_a, 0);
    check_val("set_no_carry", carry_a, 0);
    cyc();

    // both buttons held counts as none
    up_a = 1'b1; dn_a = 1'b1;
    repeat (6) begin
      cyc();
      check_val("both_held", value_a, 0);
    end
    up_a = 1'b0; dn_a = 1'b0;
    cyc();

    // asynchronous reset while auto-repeating
    up_a = 1'b1;
    repeat (8) cyc();
    check_val("pre_reset", value_a, 3);
    #3 rst_n = 1'b0;
    #1;
    check_val("async_rst_a", value_a, 0);
    check_val("async_rst_b", value_b, 1);
    check_val("async_rst_cry", carry_a, 0);
    #2 rst_n = 1'b1;
    cyc();
    check_val("post_rst_press", value_a, 1);
    cyc();
    check_val("post_rst_hold", value_a, 1);
    up_a = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
